// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage controllers:
// state encoding, bit reversal and twiddle-index arithmetic.
package fft_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    READ = 1'b1
  } fft_state_e;

  // Reverses the low w bits of v; w must be a
  // constant (the stage address width) when synthesised.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[5'(w - 1 - i)] = v[5'(i)];
    end
    return r;
  endfunction

  // Twiddle exponent k for butterfly offset j of a
  // span-wide stage: W_N^(j * N / (2*span)).
  function automatic logic [31:0] twiddle_idx(
    input logic [31:0] j,
    input logic [31:0] n,
    input logic [31:0] span
  );
    return j * (n / (2 * span));
  endfunction

endpackage

// File: rtl/fft_rd_addr_gen.sv
// Maps a read counter to butterfly-pair RAM address and twiddle index.
// Ports: rd_cnt_i (counter) -> rd_ptr_o (address), rd_angle_o (twiddle).
module fft_rd_addr_gen
  import fft_pkg::*;
#(
  parameter int N     = 16,
  parameter int SIZE  = 4,
  parameter int STAGE = 4
) (
  input  logic [SIZE-1:0] rd_cnt_i,
  output logic [SIZE-1:0] rd_ptr_o,
  output logic [SIZE-2:0] rd_angle_o
);

  localparam logic [31:0] SPAN = 32'(1) << (STAGE - 1);
  localparam logic [31:0] NN   = 32'(N);

  logic [31:0] b;
  logic [31:0] j;
  logic [31:0] top;

  // Spans are powers of two, so the divide/modulo
  // reduce to bit slicing after constant folding.
  always_comb begin
    b   = 32'(rd_cnt_i >> 1);
    j   = b % SPAN;
    top = (b / SPAN) * (2 * SPAN) + j;
    rd_ptr_o   = rd_cnt_i[0] ? SIZE'(top + SPAN)
                             : SIZE'(top);
    rd_angle_o = (SIZE-1)'(twiddle_idx(j, NN, SPAN));
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Radix-2 DIT stage sequencer: bit-reversed buffer load, then pair-order
// reads with twiddle index. Ports: in_* upstream, load/Re/Im write, en_rd/rd_* read.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4,
  parameter int STAGE     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [bit_width-1:0] in_re,
  input  logic signed [bit_width-1:0] in_im,
  input  logic                        rd_hold,
  output logic                        load_data,
  output logic [SIZE-1:0]             invert_adr,
  output logic signed [bit_width-1:0] Re_i,
  output logic signed [bit_width-1:0] Im_i,
  output logic                        en_rd,
  output logic [SIZE-1:0]             rd_ptr,
  output logic [SIZE-2:0]             rd_angle_ptr,
  output logic                        frame_done
);

  localparam logic [SIZE-1:0] LAST = SIZE'(N - 1);

  fft_state_e state_q, state_d;

  logic [SIZE-1:0] wr_cnt_q, wr_cnt_d;
  logic [SIZE-1:0] rd_cnt_q, rd_cnt_d;
  logic            rdy_q, rdy_d;
  logic            load_q, load_d;
  logic [SIZE-1:0] adr_q, adr_d;
  logic signed [bit_width-1:0] re_q, re_d;
  logic signed [bit_width-1:0] im_q, im_d;
  logic            en_q, en_d;
  logic [SIZE-1:0] ptr_q, ptr_d;
  logic [SIZE-2:0] ang_q, ang_d;
  logic            done_q, done_d;

  logic [SIZE-1:0] ptr_c;
  logic [SIZE-2:0] ang_c;

  fft_rd_addr_gen #(
    .N     (N),
    .SIZE  (SIZE),
    .STAGE (STAGE)
  ) u_addr (
    .rd_cnt_i   (rd_cnt_q),
    .rd_ptr_o   (ptr_c),
    .rd_angle_o (ang_c)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    rdy_d    = rdy_q;
    load_d   = 1'b0;
    adr_d    = adr_q;
    re_d     = re_q;
    im_d     = im_q;
    en_d     = 1'b0;
    ptr_d    = ptr_q;
    ang_d    = ang_q;
    done_d   = 1'b0;
    unique case (state_q)
      LOAD: begin
        rdy_d = 1'b1;
        // rdy_q gates acceptance: the first LOAD
        // cycle after a frame still shows not-ready.
        if (in_valid && rdy_q) begin
          load_d   = 1'b1;
          adr_d    = SIZE'(bitrev(32'(wr_cnt_q), SIZE));
          re_d     = in_re;
          im_d     = in_im;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST) begin
            wr_cnt_d = '0;
            state_d  = READ;
            rdy_d    = 1'b0;
          end
        end
      end
      READ: begin
        rdy_d = 1'b0;
        if (!rd_hold) begin
          en_d     = 1'b1;
          ptr_d    = ptr_c;
          ang_d    = ang_c;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST) begin
            done_d   = 1'b1;
            rd_cnt_d = '0;
            state_d  = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      rdy_q    <= 1'b1;
      load_q   <= 1'b0;
      adr_q    <= '0;
      re_q     <= '0;
      im_q     <= '0;
      en_q     <= 1'b0;
      ptr_q    <= '0;
      ang_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      rdy_q    <= rdy_d;
      load_q   <= load_d;
      adr_q    <= adr_d;
      re_q     <= re_d;
      im_q     <= im_d;
      en_q     <= en_d;
      ptr_q    <= ptr_d;
      ang_q    <= ang_d;
      done_q   <= done_d;
    end
  end

  assign in_ready     = rdy_q;
  assign load_data    = load_q;
  assign invert_adr   = adr_q;
  assign Re_i         = re_q;
  assign Im_i         = im_q;
  assign en_rd        = en_q;
  assign rd_ptr       = ptr_q;
  assign rd_angle_ptr = ang_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: four instances (STAGE 4..1) share stimulus,
// each checked against butterfly tables built from the stage rules.
module tb_fft_stage_ctrl;

  localparam int ND = 4;
  localparam int NN = 16;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic rd_hold;
  logic signed [28:0] in_re;
  logic signed [28:0] in_im;

  logic               rdy_w  [ND];
  logic               load_w [ND];
  logic [3:0]         adr_w  [ND];
  logic signed [28:0] re_w   [ND];
  logic signed [28:0] im_w   [ND];
  logic               en_w   [ND];
  logic [3:0]         ptr_w  [ND];
  logic [2:0]         ang_w  [ND];
  logic               done_w [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    fft_stage_ctrl #(
      .bit_width (29),
      .N         (16),
      .SIZE      (4),
      .STAGE     (4 - g)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (rdy_w[g]),
      .in_re        (in_re),
      .in_im        (in_im),
      .rd_hold      (rd_hold),
      .load_data    (load_w[g]),
      .invert_adr   (adr_w[g]),
      .Re_i         (re_w[g]),
      .Im_i         (im_w[g]),
      .en_rd        (en_w[g]),
      .rd_ptr       (ptr_w[g]),
      .rd_angle_ptr (ang_w[g]),
      .frame_done   (done_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  int exp_ptr [ND][NN];
  int exp_ang [ND][NN];
  int exp_adr;
  int exp_lptr [ND];
  int exp_lang [ND];
  logic signed [28:0] exp_re;
  logic signed [28:0] exp_im;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int rev4(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic string tg(input string s, input int d);
    return $sformatf("%s[stage%0d]", s, 4 - d);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write_hold(input int d);
    chk(tg("invert_adr", d), 64'(adr_w[d]), 64'(exp_adr));
    chk(tg("Re_i", d), re_w[d], exp_re);
    chk(tg("Im_i", d), im_w[d], exp_im);
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk(tg({tag, "_ready"}, d), 64'(rdy_w[d]), 64'(1));
      chk(tg({tag, "_load"}, d), 64'(load_w[d]), 64'(0));
      chk(tg({tag, "_adr"}, d), 64'(adr_w[d]), 64'(0));
      chk(tg({tag, "_re"}, d), re_w[d], 64'(0));
      chk(tg({tag, "_im"}, d), im_w[d], 64'(0));
      chk(tg({tag, "_en"}, d), 64'(en_w[d]), 64'(0));
      chk(tg({tag, "_ptr"}, d), 64'(ptr_w[d]), 64'(0));
      chk(tg({tag, "_ang"}, d), 64'(ang_w[d]), 64'(0));
      chk(tg({tag, "_done"}, d), 64'(done_w[d]), 64'(0));
    end
  endtask

  task automatic clr_model();
    exp_adr = 0;
    exp_re  = '0;
    exp_im  = '0;
    for (int d = 0; d < ND; d++) begin
      exp_lptr[d] = 0;
      exp_lang[d] = 0;
    end
  endtask

  // Loads n samples; gaps=1 inserts random idle cycles.
  task automatic do_load(input int n, input bit gaps,
                         input bit seq);
    int k = 0;
    int cyc = 0;
    bit v;
    logic signed [28:0] dr, di;
    while (k < n && cyc < 200) begin
      for (int d = 0; d < ND; d++)
        chk(tg("in_ready_load", d), 64'(rdy_w[d]), 64'(1));
      v  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      dr = seq ? 29'(k) : 29'($urandom);
      di = seq ? 29'(100 + k) : 29'($urandom);
      in_valid = v;
      in_re    = dr;
      in_im    = di;
      rd_hold  = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (v) begin
        exp_adr = rev4(k);
        exp_re  = dr;
        exp_im  = di;
        k++;
      end
      for (int d = 0; d < ND; d++) begin
        chk(tg("load_data", d), 64'(load_w[d]), 64'(v));
        chk_write_hold(d);
        chk(tg("en_rd_load", d), 64'(en_w[d]), 64'(0));
        chk(tg("done_load", d), 64'(done_w[d]), 64'(0));
      end
    end
    if (k < n) begin
      total++;
      bad++;
      $error("FAIL load_timeout observed=%0d expected=%0d",
             k, n);
    end
    in_valid = 1'b0;
  endtask

  // hmode: 0 none, 1 three-cycle hold after 5th read, 2 random.
  task automatic do_read(input int hmode, input bit vread);
    int r = 0;
    int held = 0;
    int cyc = 0;
    bit h;
    while (r < NN && cyc < 100) begin
      h = 1'b0;
      if (hmode == 1) h = (r == 5 && held < 3);
      if (hmode == 2) h = ($urandom_range(0, 3) == 0);
      if (h) held++;
      rd_hold  = h;
      in_valid = vread;
      in_re    = 29'($urandom);
      in_im    = 29'($urandom);
      tick();
      cyc++;
      for (int d = 0; d < ND; d++) begin
        chk(tg("load_read", d), 64'(load_w[d]), 64'(0));
        chk(tg("in_ready_read", d), 64'(rdy_w[d]), 64'(0));
        chk_write_hold(d);
        if (h) begin
          chk(tg("en_rd_hold", d), 64'(en_w[d]), 64'(0));
          chk(tg("done_hold", d), 64'(done_w[d]), 64'(0));
          chk(tg("ptr_hold", d), 64'(ptr_w[d]),
              64'(exp_lptr[d]));
          chk(tg("ang_hold", d), 64'(ang_w[d]),
              64'(exp_lang[d]));
        end else begin
          exp_lptr[d] = exp_ptr[d][r];
          exp_lang[d] = exp_ang[d][r];
          chk(tg("en_rd", d), 64'(en_w[d]), 64'(1));
          chk(tg("rd_ptr", d), 64'(ptr_w[d]),
              64'(exp_lptr[d]));
          chk(tg("rd_angle", d), 64'(ang_w[d]),
              64'(exp_lang[d]));
          chk(tg("frame_done", d), 64'(done_w[d]),
              64'(r == NN - 1));
        end
      end
      if (!h) r++;
    end
    if (r < NN) begin
      total++;
      bad++;
      $error("FAIL read_timeout observed=%0d expected=%0d",
             r, NN);
    end
    // Turnaround cycle: not yet ready, input ignored.
    rd_hold  = 1'b0;
    in_valid = vread;
    tick();
    for (int d = 0; d < ND; d++) begin
      chk(tg("turn_load", d), 64'(load_w[d]), 64'(0));
      chk(tg("turn_en", d), 64'(en_w[d]), 64'(0));
      chk(tg("turn_done", d), 64'(done_w[d]), 64'(0));
      chk(tg("turn_ready", d), 64'(rdy_w[d]), 64'(1));
      chk_write_hold(d);
    end
    in_valid = 1'b0;
  endtask

  task automatic after_load();
    for (int d = 0; d < ND; d++)
      chk(tg("ready_drop", d), 64'(rdy_w[d]), 64'(0));
  endtask

  initial begin
    int idx;
    int span;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    rd_hold  = 1'b0;
    in_re    = '0;
    in_im    = '0;
    clr_model();

    // Butterfly tables: pairs (top, top+span) per group.
    for (int d = 0; d < ND; d++) begin
      span = 1 << (3 - d);
      idx  = 0;
      for (int g = 0; g < NN / (2 * span); g++) begin
        for (int j = 0; j < span; j++) begin
          exp_ptr[d][idx]   = g * 2 * span + j;
          exp_ang[d][idx]   = (j * (NN / (2 * span))) % 8;
          exp_ptr[d][idx+1] = g * 2 * span + j + span;
          exp_ang[d][idx+1] = exp_ang[d][idx];
          idx += 2;
        end
      end
    end

    repeat (2) tick();
    chk_reset_outs("reset");
    rst_n = 1'b1;

    do_load(NN, 1'b0, 1'b1);
    after_load();
    do_read(0, 1'b0);

    do_load(NN, 1'b1, 1'b0);
    after_load();
    do_read(1, 1'b1);

    do_load(7, 1'b1, 1'b0);
    #3;
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    clr_model();
    chk_reset_outs("async_rst");
    tick();
    chk_reset_outs("rst_held");
    in_valid = 1'b0;
    rst_n = 1'b1;

    for (int f = 0; f < 4; f++) begin
      do_load(NN, 1'b1, f[0]);
      after_load();
      do_read(2, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencer for one radix-2 DIT FFT stage. It writes an incoming complex sample stream into the stage's ping buffer at bit-reversed addresses, then reads it back in butterfly-pair order with the matching twiddle-ROM index. It drives the buffer's write port (`load_data`, `invert_adr`, `Re_i`, `Im_i`) and read port (`en_rd`, `rd_ptr`, `rd_angle_ptr`), and sits between the upstream sample source and the stage RAM.

## Interface

Parameters:
- `bit_width`, 29: sample component width.
- `N`, 16: FFT length (power of 2, at least 4).
- `SIZE`, 4: log2(N); address width.
- `STAGE`, 4: stage number, 1..SIZE; sets butterfly span = 2^(STAGE-1).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: sample present on `in_re`/`in_im`.
- `in_ready` out 1: block accepts a sample this cycle.
- `in_re`, `in_im` in bit_width signed: input sample.
- `rd_hold` in 1: downstream stall; freezes the read sequence.
- `load_data` out 1: buffer write enable.
- `invert_adr` out SIZE: bit-reversed write address.
- `Re_i`, `Im_i` out bit_width signed: registered write data.
- `en_rd` out 1: buffer read enable.
- `rd_ptr` out SIZE: read address.
- `rd_angle_ptr` out SIZE-1: twiddle index, W_N^k with k = 0..N/2-1.
- `frame_done` out 1: one-cycle pulse on the final read of a frame.

## Operation

- States are LOAD and READ. Reset state is LOAD.
- Reset values: `wr_cnt`=0, `rd_cnt`=0, `in_ready`=1, and every other output is 0.

LOAD:
- `in_ready`=1.
- On `in_valid`, register `load_data`=1, `invert_adr`=bitrev(`wr_cnt`), `Re_i`/`Im_i`=`in_re`/`in_im`, then increment `wr_cnt`.
- Without `in_valid`, `load_data`=0 and the other write outputs hold.
- When the sample accepted has `wr_cnt`=N-1: `wr_cnt` wraps to 0, the state goes to READ, and `in_ready` drops the same edge.

READ:
- `in_ready`=0 and `load_data`=0 after the final write beat.
- Each cycle with `rd_hold`=0, register `en_rd`=1, `rd_ptr`, `rd_angle_ptr`, and increment `rd_cnt` (0..N-1).
- With `rd_hold`=1, `en_rd`=0, and `rd_cnt`, `rd_ptr` and `rd_angle_ptr` hold.

Read address arithmetic, with b = `rd_cnt`>>1, span = 2^(STAGE-1), j = b mod span:
- top = (b / span)·2·span + j.
- `rd_ptr` = top when `rd_cnt`[0]=0, else top+span.
- `rd_angle_ptr` = j·(N/(2·span)), truncated to SIZE-1 bits. Both reads of a pair carry the same angle.

End of READ:
- When `rd_cnt`=N-1 is issued, `frame_done`=1 for that cycle.
- `rd_cnt` wraps to 0, the state returns to LOAD, and `in_ready`=1 from the next cycle.

Boundary behaviour:
- `in_valid` during READ is ignored; no write occurs and the sample is not counted.
- Asserting `rst_n` low mid-frame aborts immediately. The partial frame is discarded and the next frame starts at `wr_cnt`=0.

## Timing

- Write latency: 1 cycle from the `in_valid`&&`in_ready` edge to `load_data`. The RAM commits on the following edge.
- First `en_rd` is registered on the edge after the last `load_data` edge. This guarantees the final write is in memory before the first read.
- Read sequence is N cycles when unstalled. Unstalled frame period is 2N+1 cycles.
- `rd_hold` acts on the same edge: the cycle after `rd_hold` rises shows `en_rd`=0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Shared package `fft_pkg` holds:
  - the state enum (LOAD, READ);
  - a `bitrev` function parameterised on SIZE;
  - the twiddle-index formula as a function.
- One natural sub-module, `fft_rd_addr_gen`: combinational mapping from `rd_cnt` to `rd_ptr`/`rd_angle_ptr`, parameterised on N and STAGE. It is reused by the other stage controllers.

## Test plan

- N=16: send samples 0..15 back-to-back -> `invert_adr` sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with `Re_i` equal to the sample value.
- STAGE=4, no stall -> `rd_ptr` 0,8,1,9,2,10,…,7,15; `rd_angle_ptr` 0,0,1,1,…,7,7; `frame_done` on the 16th read only.
- STAGE=2 -> `rd_ptr` 0,2,1,3,4,6,5,7,…; `rd_angle_ptr` 0,0,4,4 repeating. STAGE=1 -> `rd_ptr` 0..15 in order, angle always 0.
- `rd_hold` high for 3 cycles after the 5th read -> `en_rd` low for exactly 3 cycles; reads 6..16 are unchanged and `frame_done` is delayed by 3 cycles.
- `in_valid` held high through READ, plus gaps in `in_valid` during LOAD -> no extra writes, `wr_cnt` continuity intact, `in_ready`=0 throughout READ.
- `rst_n` pulsed low after 7 writes -> all outputs 0 and `in_ready`=1 immediately; the next 16 samples complete a correct frame.
